caliptra_fpga_sync_axil_initiator: RTL and testbench
====================================================

Name: caliptra_fpga_sync_axil_initiator

Overview:
AXI4-Lite initiator, 64-bit data and 32-bit address, for the FPGA sync subsystem. It turns a single-outstanding command/response interface into AXI4-Lite read or write transactions. Its main use is polling the sync register block, for example sampling the free-running 64-bit counter, from local logic. It also reports per-transaction bus latency for sync-skew measurement.

Parameters:
LAT_W, 16, width of the saturating latency counter reported with each response

Ports:
aclk  in  1  clock
rstn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  32  byte address
cmd_wdata  in  64  write data
cmd_wstrb  in  8  write byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_data  out  64  read data (0 for writes)
rsp_resp  out  2  RRESP/BRESP of the transaction
rsp_write  out  1  response belongs to a write
rsp_latency  out  LAT_W  bus cycles, saturating
arvalid/arready/araddr[31:0]/arprot[2:0]  AXI read address channel, initiator side
rvalid/rready/rdata[63:0]/rresp[1:0]  AXI read data channel, initiator side
awvalid/awready/awaddr[31:0]/awprot[2:0]  AXI write address channel, initiator side
wvalid/wready/wdata[63:0]/wstrb[7:0]  AXI write data channel, initiator side
bvalid/bready/bresp[1:0]  AXI write response channel, initiator side

Behaviour:
- Clock and reset: one clock, aclk. Reset is asynchronous and active-low on rstn.
- Reset values: state IDLE; cmd_ready 1; all *valid and *ready outputs 0; rsp_* 0; address and data registers 0.
- Reset mid-transaction: return to IDLE immediately. No completion is produced.
- Protection fields: arprot and awprot are constant 3'b000.
- Outstanding limit: one transaction at a time.
- FSM states: IDLE, RD_A, RD_D, WR_AW, WR_B, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr/wdata/wstrb/write and clear the latency counter.
  - Go to RD_A (read) or WR_AW (write).
- Issue timing: arvalid or awvalid+wvalid asserts on the first cycle after command acceptance. There is no combinational path from cmd_* to AXI outputs.
- RD_A:
  - arvalid=1, araddr=latched address.
  - On arready, go to RD_D and drop arvalid the following cycle.
- RD_D:
  - rready=1.
  - On rvalid, capture rdata/rresp and go to RSP.
- WR_AW:
  - awvalid and wvalid both assert in the first cycle.
  - Each drops independently on its own handshake; per-channel done flags track this.
  - Move to WR_B once both are done, including when both handshake in the same cycle.
  - W handshaking before AW is legal, and so is the reverse.
- WR_B:
  - bready=1.
  - On bvalid, capture bresp, set rsp_data=0, go to RSP.
- Payload stability: once a valid is asserted, payload is held stable and valid is not deasserted before its ready.
- Early responses: rvalid or bvalid arriving in RD_A or WR_AW is not accepted (rready/bready stay 0) until the matching state.
- RSP:
  - rsp_valid=1; outputs hold until rsp_ready.
  - On handshake go to IDLE; cmd_ready is 1 in the next cycle.
- Latency counter:
  - Increments every cycle the FSM is in RD_A, RD_D, WR_AW or WR_B.
  - rsp_latency is the count of cycles from the first valid cycle through the R/B handshake cycle, inclusive. Minimum 2.
  - Saturates at 2^LAT_W-1; it does not wrap.
- Error responses: rsp_resp passes RRESP/BRESP through unchanged. SLVERR and DECERR are not retried.

Test Plan:
- Read, zero wait: cmd read addr 0x0, responder arready=1, rvalid the cycle after AR with rdata 0x0000_0001_0000_002A, rresp 0 -> arvalid high exactly 1 cycle; rsp_data 0x0000_0001_0000_002A, rsp_resp 0, rsp_latency 2, rsp_write 0.
- Write, W before AW: cmd write addr 0x8, wdata 0xDEAD_BEEF_0123_4567, wstrb 0xFF; wready at cycle 1, awready at cycle 4, bvalid at cycle 6 -> wvalid drops after cycle 1; awvalid held with stable awaddr 0x8 through cycle 4; bready only in WR_B; rsp_latency 6, rsp_data 0, rsp_write 1.
- Backpressure: rvalid delayed 300 cycles with LAT_W=8 -> rsp_latency 255 (saturated); rready held high throughout RD_D.
- Response stall: rsp_ready low 5 cycles -> rsp_* stable, cmd_ready 0; a new cmd_valid is not accepted until the cycle after the handshake.
- Error: bresp 2'b10 -> rsp_resp 2'b10; FSM returns to IDLE and the next read completes normally.
- Async reset: rstn low while in WR_AW with awvalid=1 -> awvalid, wvalid and rsp_valid go to 0 before the next aclk edge; after release cmd_ready=1 and no spurious response.

Source files
------------

// File: rtl/caliptra_fpga_sync_axil_initiator.sv
// Single-outstanding AXI4-Lite initiator for the FPGA sync register block.
// Turns cmd/rsp requests into AXI-Lite reads/writes and reports bus latency.
module caliptra_fpga_sync_axil_initiator #(
   parameter int LAT_W = 16
) (
   input  logic             aclk,
   input  logic             rstn,
   // Command/response side. A transfer happens when valid and ready are both
   // high at a rising aclk edge; valid never drops and payload never changes
   // before that edge, on every channel in both directions.
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [31:0]      cmd_addr,
   input  logic [63:0]      cmd_wdata,
   input  logic [7:0]       cmd_wstrb,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [63:0]      rsp_data,
   output logic [1:0]       rsp_resp,
   output logic             rsp_write,
   output logic [LAT_W-1:0] rsp_latency,
   output logic             arvalid,
   input  logic             arready,
   output logic [31:0]      araddr,
   output logic [2:0]       arprot,
   input  logic             rvalid,
   output logic             rready,
   input  logic [63:0]      rdata,
   input  logic [1:0]       rresp,
   output logic             awvalid,
   input  logic             awready,
   output logic [31:0]      awaddr,
   output logic [2:0]       awprot,
   output logic             wvalid,
   input  logic             wready,
   output logic [63:0]      wdata,
   output logic [7:0]       wstrb,
   input  logic             bvalid,
   output logic             bready,
   input  logic [1:0]       bresp,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_A  = 3'd1,
      RD_D  = 3'd2,
      WR_AW = 3'd3,
      WR_B  = 3'd4,
      RSP   = 3'd5
   } state_t;

   state_t           state;
   logic [31:0]      addr_q;
   logic [63:0]      wdata_q;
   logic [7:0]       wstrb_q;
   logic             aw_done;
   logic             w_done;
   logic [LAT_W-1:0] lat_cnt;
   logic [LAT_W-1:0] lat_next;
   logic             aw_fin;
   logic             w_fin;

   assign araddr    = addr_q;
   assign awaddr    = addr_q;
   assign wdata     = wdata_q;
   assign wstrb     = wstrb_q;
   assign arprot    = 3'b000;
   assign awprot    = 3'b000;
   assign dbg_state = state;

   // Count including the current cycle, clamped at all-ones.
   assign lat_next = (lat_cnt == {LAT_W{1'b1}}) ? lat_cnt : lat_cnt + LAT_W'(1);
   assign aw_fin   = aw_done | (awvalid & awready);
   assign w_fin    = w_done | (wvalid & wready);

   always_ff @(posedge aclk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         cmd_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_resp    <= '0;
         rsp_write   <= 1'b0;
         rsp_latency <= '0;
         arvalid     <= 1'b0;
         rready      <= 1'b0;
         awvalid     <= 1'b0;
         wvalid      <= 1'b0;
         bready      <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         lat_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  addr_q    <= cmd_addr;
                  wdata_q   <= cmd_wdata;
                  wstrb_q   <= cmd_wstrb;
                  lat_cnt   <= '0;
                  cmd_ready <= 1'b0;
                  if (cmd_write) begin
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                     aw_done <= 1'b0;
                     w_done  <= 1'b0;
                     state   <= WR_AW;
                  end else begin
                     arvalid <= 1'b1;
                     state   <= RD_A;
                  end
               end
            end
            RD_A: begin
               lat_cnt <= lat_next;
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= RD_D;
               end
            end
            RD_D: begin
               lat_cnt <= lat_next;
               if (rvalid) begin
                  rready      <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_data    <= rdata;
                  rsp_resp    <= rresp;
                  rsp_write   <= 1'b0;
                  rsp_latency <= lat_next;
                  state       <= RSP;
               end
            end
            WR_AW: begin
               // AW and W retire independently; leave once both have.
               lat_cnt <= lat_next;
               if (awvalid && awready) awvalid <= 1'b0;
               if (wvalid && wready) wvalid <= 1'b0;
               aw_done <= aw_fin;
               w_done  <= w_fin;
               if (aw_fin && w_fin) begin
                  bready <= 1'b1;
                  state  <= WR_B;
               end
            end
            WR_B: begin
               lat_cnt <= lat_next;
               if (bvalid) begin
                  bready      <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_data    <= '0;
                  rsp_resp    <= bresp;
                  rsp_write   <= 1'b1;
                  rsp_latency <= lat_next;
                  state       <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_caliptra_fpga_sync_axil_initiator.sv
// Directed bench: table of transactions against a cycle-scripted AXI responder,
// plus hand sequences for response stall and asynchronous reset.
module tb_caliptra_fpga_sync_axil_initiator;

   localparam int LAT_W = 8;

   logic             aclk = 1'b0;
   logic             rstn = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic             cmd_write = 1'b0;
   logic [31:0]      cmd_addr = '0;
   logic [63:0]      cmd_wdata = '0;
   logic [7:0]       cmd_wstrb = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [63:0]      rsp_data;
   logic [1:0]       rsp_resp;
   logic             rsp_write;
   logic [LAT_W-1:0] rsp_latency;
   logic             arvalid;
   logic             arready = 1'b0;
   logic [31:0]      araddr;
   logic [2:0]       arprot;
   logic             rvalid = 1'b0;
   logic             rready;
   logic [63:0]      rdata = '0;
   logic [1:0]       rresp = '0;
   logic             awvalid;
   logic             awready = 1'b0;
   logic [31:0]      awaddr;
   logic [2:0]       awprot;
   logic             wvalid;
   logic             wready = 1'b0;
   logic [63:0]      wdata;
   logic [7:0]       wstrb;
   logic             bvalid = 1'b0;
   logic             bready;
   logic [1:0]       bresp = '0;
   logic [2:0]       dbg_state;

   int n_total = 0;
   int n_pass  = 0;

   caliptra_fpga_sync_axil_initiator #(.LAT_W(LAT_W)) dut (
      .aclk(aclk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_resp(rsp_resp), .rsp_write(rsp_write), .rsp_latency(rsp_latency),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .dbg_state(dbg_state)
   );

   always #5 aclk = ~aclk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   // a_at: cycle of AR (read) or AW (write) handshake; w_at: W handshake cycle;
   // d_start: first cycle rvalid/bvalid is raised. Cycle 1 is the first cycle after acceptance.
   typedef struct {
      bit          write;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
      int          a_at;
      int          w_at;
      int          d_start;
      logic [63:0] rdata;
      logic [1:0]  resp;
      int          stall;
      logic [63:0] exp_data;
      int          exp_lat;
   } vec_t;

   vec_t tbl[8];

   function automatic vec_t mk(bit wr, logic [31:0] a, logic [63:0] wd, logic [7:0] ws,
                               int a_at, int w_at, int d_start, logic [63:0] rd,
                               logic [1:0] resp, int stall, logic [63:0] ed, int el);
      vec_t v;
      v.write = wr;   v.addr = a;       v.wdata = wd;       v.wstrb = ws;
      v.a_at = a_at;  v.w_at = w_at;    v.d_start = d_start; v.rdata = rd;
      v.resp = resp;  v.stall = stall;  v.exp_data = ed;     v.exp_lat = el;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Called at a negedge in IDLE; returns at the negedge of cycle 1.
   task automatic issue(input vec_t v);
      chk("cmd_ready_before_issue", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_write = v.write;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      cmd_wstrb = v.wstrb;
      @(posedge aclk);
      @(negedge aclk);
      cmd_valid = 1'b0;
      cmd_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      cmd_addr  = 32'hFFFF_FFFF;
   endtask

   task automatic bus(input vec_t v);
      int  viol;
      int  mx;
      bit  done;
      viol = 0;
      done = 1'b0;
      mx = (v.a_at > v.w_at) ? v.a_at : v.w_at;
      for (int k = 1; k <= 1000; k++) begin
         if (rsp_valid) begin
            done = 1'b1;
            break;
         end
         if (!v.write) begin
            if (arvalid !== 1'(k <= v.a_at)) viol++;
            if (arvalid && araddr !== v.addr) viol++;
            if (rready !== 1'(k > v.a_at)) viol++;
            if (awvalid || wvalid || bready) viol++;
            arready = (k == v.a_at);
            rvalid  = (k >= v.d_start);
            rdata   = rvalid ? v.rdata : 64'hBAD0_BAD0_BAD0_BAD0;
            rresp   = rvalid ? v.resp : ~v.resp;
         end else begin
            if (awvalid !== 1'(k <= v.a_at)) viol++;
            if (wvalid !== 1'(k <= v.w_at)) viol++;
            if (bready !== 1'(k > mx)) viol++;
            if (awvalid && awaddr !== v.addr) viol++;
            if (wvalid && (wdata !== v.wdata || wstrb !== v.wstrb)) viol++;
            if (arvalid || rready) viol++;
            awready = (k == v.a_at);
            wready  = (k == v.w_at);
            bvalid  = (k >= v.d_start);
            bresp   = bvalid ? v.resp : ~v.resp;
            rvalid  = 1'b1;
            rdata   = 64'hBAD1_BAD1_BAD1_BAD1;
         end
         if (arprot !== 3'b000 || awprot !== 3'b000) viol++;
         @(posedge aclk);
         @(negedge aclk);
      end
      arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      rdata = '0; rresp = '0; bresp = '0;
      chk("response_arrived", done, 1);
      chk("bus_protocol_violations", viol, 0);
      chk("rsp_data", rsp_data, v.exp_data);
      chk("rsp_resp", rsp_resp, v.resp);
      chk("rsp_write", rsp_write, v.write);
      chk("rsp_latency", rsp_latency, v.exp_lat);
   endtask

   task automatic consume(input vec_t v);
      int bad;
      bad = 0;
      for (int i = 0; i < v.stall; i++) begin
         @(posedge aclk);
         @(negedge aclk);
         if (!rsp_valid || cmd_ready || rsp_data !== v.exp_data || rsp_resp !== v.resp ||
             rsp_write !== v.write || rsp_latency !== LAT_W'(v.exp_lat)) bad++;
      end
      if (v.stall > 0) chk("rsp_stable_during_stall", bad, 0);
      rsp_ready = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      rsp_ready = 1'b0;
      chk("rsp_valid_after_handshake", rsp_valid, 0);
      chk("cmd_ready_after_handshake", cmd_ready, 1);
   endtask

   initial begin
      vec_t v;
      vec_t w;
      int   bad;

      tbl[0] = mk(0, 32'h0, 64'h0, 8'h00, 1, 0, 2, 64'h0000_0001_0000_002A, 2'b00, 0, 64'h0000_0001_0000_002A, 2);
      tbl[1] = mk(1, 32'h8, 64'hDEAD_BEEF_0123_4567, 8'hFF, 4, 1, 6, 64'h0, 2'b00, 0, 64'h0, 6);
      tbl[2] = mk(1, 32'h10, 64'h1111_2222_3333_4444, 8'hF0, 2, 5, 3, 64'h0, 2'b00, 0, 64'h0, 6);
      tbl[3] = mk(1, 32'h18, 64'hA5A5_5A5A_0F0F_F0F0, 8'h0F, 3, 3, 4, 64'h0, 2'b10, 0, 64'h0, 4);
      tbl[4] = mk(0, 32'h1000_0010, 64'h0, 8'h00, 3, 0, 2, 64'h0123_4567_89AB_CDEF, 2'b11, 0, 64'h0123_4567_89AB_CDEF, 4);
      tbl[5] = mk(0, 32'h20, 64'h0, 8'h00, 2, 0, 5, 64'hFEDC_BA98_7654_3210, 2'b00, 0, 64'hFEDC_BA98_7654_3210, 5);
      tbl[6] = mk(0, 32'h28, 64'h0, 8'h00, 1, 0, 300, 64'h0000_0000_0000_0300, 2'b00, 0, 64'h0000_0000_0000_0300, 255);
      tbl[7] = mk(1, 32'h30, 64'h0BAD_F00D_CAFE_0001, 8'h3C, 1, 1, 2, 64'h0, 2'b01, 5, 64'h0, 2);

      // Reset values
      repeat (2) @(negedge aclk);
      chk("reset_cmd_ready", cmd_ready, 1);
      chk("reset_valids", {arvalid, awvalid, wvalid, rready, bready, rsp_valid}, 0);
      chk("reset_rsp_fields", {rsp_data, rsp_resp, rsp_write, rsp_latency}, 0);
      chk("reset_state", dbg_state, 0);
      rstn = 1'b1;
      @(negedge aclk);
      chk("post_reset_cmd_ready", cmd_ready, 1);

      for (int i = 0; i < 8; i++) begin
         issue(tbl[i]);
         bus(tbl[i]);
         consume(tbl[i]);
      end

      // Response stall while a new command is already pending
      v = mk(0, 32'h40, 64'h0, 8'h00, 1, 0, 3, 64'h5555_AAAA_5555_AAAA, 2'b00, 0, 64'h5555_AAAA_5555_AAAA, 3);
      w = mk(1, 32'h48, 64'h7777_8888_9999_AAAA, 8'hC3, 2, 2, 3, 64'h0, 2'b00, 0, 64'h0, 3);
      issue(v);
      bus(v);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = w.addr; cmd_wdata = w.wdata; cmd_wstrb = w.wstrb;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge aclk);
         @(negedge aclk);
         if (cmd_ready || awvalid || wvalid || !rsp_valid || rsp_data !== v.exp_data) bad++;
      end
      chk("pending_cmd_blocked_in_rsp", bad, 0);
      rsp_ready = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      rsp_ready = 1'b0;
      chk("cmd_ready_cycle_after_rsp", cmd_ready, 1);
      chk("no_issue_in_handshake_cycle", awvalid, 0);
      @(posedge aclk);
      @(negedge aclk);
      cmd_valid = 1'b0;
      chk("pending_cmd_issued", {awvalid, wvalid}, 2'b11);
      bus(w);
      consume(w);

      // Asynchronous reset in the middle of a write
      issue(tbl[1]);
      chk("in_wr_aw_before_reset", {awvalid, wvalid, dbg_state}, {2'b11, 3'd3});
      #2;
      rstn = 1'b0;
      #1;
      chk("async_reset_valids", {awvalid, wvalid, rsp_valid}, 0);
      chk("async_reset_cmd_ready", cmd_ready, 1);
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      rstn = 1'b1;
      awready = 1'b1; wready = 1'b1; bvalid = 1'b1; rvalid = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge aclk);
         @(negedge aclk);
         if (rsp_valid || awvalid || wvalid || bready || rready || !cmd_ready) bad++;
      end
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
      chk("no_spurious_after_reset", bad, 0);
      issue(tbl[0]);
      bus(tbl[0]);
      consume(tbl[0]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
